fft_frame_sequencer: RTL and testbench

//  Parametrised frame sequencer for the FFT engine: accepts complex samples over a valid/ready

---
 rtl/fft_frame_sequencer_if.sv | 44 ++++
 rtl/fft_frame_sequencer.sv | 156 +++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_sequencer_if.sv
// Stream/core bundle for fft_frame_sequencer.
//   ena, abort            : clock enable and synchronous flush
//   in_valid/in_ready/in_data : complex sample stream {real, imag}
//   core_start/core_samples   : frame handed to the external FFT core
//   core_done/core_result     : bins returned by the core
//   out_valid/out_ready/out_data/out_index/out_last : reduced bin stream
//   status, frame_count       : sequencer state for the top level
// master = environment side, slave = sequencer side.
interface fft_frame_sequencer_if #(
  parameter int N_POINTS = 4,
  parameter int DATA_W   = 8,
  parameter int OUT_W    = 4
);
  localparam int IW = $clog2(N_POINTS);

  logic                         ena;
  logic                         abort;
  logic                         in_valid;
  logic                         in_ready;
  logic [2*DATA_W-1:0]          in_data;
  logic                         core_start;
  logic [N_POINTS*2*DATA_W-1:0] core_samples;
  logic                         core_done;
  logic [N_POINTS*2*DATA_W-1:0] core_result;
  logic                         out_valid;
  logic                         out_ready;
  logic [2*OUT_W-1:0]           out_data;
  logic [IW-1:0]                out_index;
  logic                         out_last;
  logic [1:0]                   status;
  logic [7:0]                   frame_count;

  modport master (
    output ena, abort, in_valid, in_data, core_done, core_result, out_ready,
    input  in_ready, core_start, core_samples, out_valid, out_data, out_index,
           out_last, status, frame_count
  );

  modport slave (
    input  ena, abort, in_valid, in_data, core_done, core_result, out_ready,
    output in_ready, core_start, core_samples, out_valid, out_data, out_index,
           out_last, status, frame_count
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: loads N_POINTS complex samples, launches the external FFT
// core on a full frame, captures its bins and streams them out reduced to OUT_W
// bits per component. The next frame may load while the current one drains.
// Ports: clk, rst (async, active-high) and bus (fft_frame_sequencer_if.slave).

// Per-component width reduction: truncate (arithmetic shift) or round-half-up
// with saturation to the signed OUT_W range.
module fft_seq_reduce #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 4,
  parameter int ROUND  = 0
) (
  input  logic [DATA_W-1:0] x_i,
  output logic [OUT_W-1:0]  y_o
);
  localparam int S = DATA_W - OUT_W;

  if (S == 0) begin : g_pass
    assign y_o = x_i;
  end else if (ROUND == 0) begin : g_trunc
    // x >>> S keeping OUT_W bits is exactly the MSB slice
    logic unused_lo;
    assign unused_lo = ^x_i[S-1:0];
    assign y_o = x_i[DATA_W-1:S];
  end else begin : g_round
    localparam logic signed [DATA_W:0] HALF = (DATA_W+1)'(1) << (S-1);
    localparam logic signed [DATA_W:0] OMAX = (DATA_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [DATA_W:0] OMIN = ~OMAX;
    logic signed [DATA_W:0] sum, shr;
    // one extra bit so x + half cannot wrap
    assign sum = $signed({x_i[DATA_W-1], x_i}) + HALF;
    assign shr = sum >>> S;
    always_comb begin
      y_o = shr[OUT_W-1:0];
      if (shr > OMAX)      y_o = OMAX[OUT_W-1:0];
      else if (shr < OMIN) y_o = OMIN[OUT_W-1:0];
    end
  end
endmodule

module fft_frame_sequencer #(
  parameter int N_POINTS = 4,
  parameter int DATA_W   = 8,
  parameter int OUT_W    = 4,
  parameter int ROUND    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_frame_sequencer_if.slave  bus
);
  localparam int IW = $clog2(N_POINTS);
  localparam int SW = 2 * DATA_W;
  localparam int FW = N_POINTS * SW;
  localparam logic [IW-1:0] LAST = IW'(N_POINTS - 1);

  logic [FW-1:0] smp_q, smp_d, res_q, res_d;
  logic [IW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic          full_q, full_d, comp_q, comp_d, pend_q, pend_d;
  logic [7:0]    cnt_q, cnt_d;

  logic live, acc, launch, done_acc, drn;
  logic [SW-1:0] cur;
  logic [1:0][OUT_W-1:0] red;

  // every event needs ena, and abort overrides all of them
  assign live     = bus.ena & ~bus.abort;
  assign acc      = live & bus.in_valid & ~full_q;
  // gated by live so a stalled cycle never shows a start the state will not record
  assign launch   = live & full_q & ~comp_q & ~pend_q;
  // comp_q is only set from the edge after core_start, so early/stray dones drop here
  assign done_acc = live & comp_q & bus.core_done;
  assign drn      = live & pend_q & bus.out_ready;

  always_comb begin
    smp_d  = smp_q;
    res_d  = res_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    full_d = full_q;
    comp_d = comp_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (bus.ena && bus.abort) begin
      smp_d  = '0;
      res_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
      full_d = 1'b0;
      comp_d = 1'b0;
      pend_d = 1'b0;
      cnt_d  = '0;
    end else begin
      if (acc) begin
        smp_d[wr_q*SW +: SW] = bus.in_data;
        wr_d = wr_q + 1'b1;               // N is a power of 2: wraps to 0 after LAST
        if (wr_q == LAST) full_d = 1'b1;
      end
      if (launch) comp_d = 1'b1;
      if (done_acc) begin
        res_d  = bus.core_result;
        comp_d = 1'b0;
        full_d = 1'b0;
        pend_d = 1'b1;
      end
      if (drn) begin
        rd_d = rd_q + 1'b1;
        if (rd_q == LAST) begin
          pend_d = 1'b0;
          cnt_d  = cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q  <= '0;
      res_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      full_q <= 1'b0;
      comp_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      smp_q  <= smp_d;
      res_q  <= res_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      full_q <= full_d;
      comp_q <= comp_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cur = res_q[rd_q*SW +: SW];

  // c=1 is the real (upper) half, c=0 the imaginary half
  for (genvar c = 0; c < 2; c++) begin : g_comp
    fft_seq_reduce #(.DATA_W(DATA_W), .OUT_W(OUT_W), .ROUND(ROUND)) u_red (
      .x_i (cur[c*DATA_W +: DATA_W]),
      .y_o (red[c])
    );
  end

  assign bus.in_ready     = ~full_q;
  assign bus.core_start   = launch;
  assign bus.core_samples = smp_q;
  assign bus.out_valid    = pend_q;
  assign bus.out_data     = red;
  assign bus.out_index    = rd_q;
  assign bus.out_last     = (rd_q == LAST);
  assign bus.status       = pend_q ? {1'b1, full_q} : {1'b0, comp_q};
  assign bus.frame_count  = cnt_q;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
module tb_fft_frame_sequencer;
  logic clk, rst;
  int n_tests = 0, n_fail = 0;
  int fc0 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fft_frame_sequencer_if #(.N_POINTS(4), .DATA_W(8),  .OUT_W(4)) if0 ();
  fft_frame_sequencer_if #(.N_POINTS(4), .DATA_W(8),  .OUT_W(4)) if1 ();
  fft_frame_sequencer_if #(.N_POINTS(8), .DATA_W(12), .OUT_W(6)) if2 ();

  fft_frame_sequencer #(.N_POINTS(4), .DATA_W(8), .OUT_W(4), .ROUND(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  fft_frame_sequencer #(.N_POINTS(4), .DATA_W(8), .OUT_W(4), .ROUND(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  fft_frame_sequencer #(.N_POINTS(8), .DATA_W(12), .OUT_W(6), .ROUND(0))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  typedef logic [7:0] b4_t [4];
  typedef struct packed { logic [7:0] s_re, s_im, r_re, r_im, exp; } v1_t;
  typedef struct packed { logic [7:0] val; logic [3:0] e0, e1; } v2_t;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // reference reduction: floor division by 2^S on the signed value
  function automatic int red(int v, int dw, int ow, int rnd);
    int x, d, q, hi, lo;
    x = (v >= (1 << (dw-1))) ? v - (1 << dw) : v;
    d = 1 << (dw - ow);
    if (rnd != 0) x = x + d / 2;
    q = x / d;
    if (x < 0 && (x % d) != 0) q = q - 1;
    if (rnd != 0) begin
      hi = (1 << (ow-1)) - 1;
      lo = -(1 << (ow-1));
      if (q > hi) q = hi;
      if (q < lo) q = lo;
    end
    return q & ((1 << ow) - 1);
  endfunction

  function automatic logic [7:0] r8(logic [7:0] re, logic [7:0] im);
    return {4'(red(int'(re), 8, 4, 0)), 4'(red(int'(im), 8, 4, 0))};
  endfunction

  function automatic logic [63:0] pack4(b4_t re, b4_t im);
    logic [63:0] p;
    for (int i = 0; i < 4; i++) p[i*16 +: 16] = {re[i], im[i]};
    return p;
  endfunction

  task automatic rnd_frame(output b4_t re, output b4_t im, output b4_t e);
    for (int i = 0; i < 4; i++) begin
      re[i] = 8'($urandom);
      im[i] = 8'($urandom);
      e[i]  = r8(re[i], im[i]);
    end
  endtask

  task automatic loadn0(input b4_t re, input b4_t im, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if0.in_valid = 1'b1;
      if0.in_data  = {re[i], im[i]};
      #1;
      chk("load_ready", if0.in_ready, 1);
      @(posedge clk); #1;
    end
    if0.in_valid = 1'b0;
  endtask

  task automatic done0(input b4_t re, input b4_t im);
    if0.core_result = pack4(re, im);
    if0.core_done   = 1'b1;
    @(posedge clk); #1;
    if0.core_done   = 1'b0;
  endtask

  task automatic drain0(input b4_t e, input string nm);
    for (int k = 0; k < 4; k++) begin
      if0.out_ready = 1'b1;
      #1;
      chk({nm, "_valid"}, if0.out_valid, 1);
      chk({nm, "_idx"},   if0.out_index, 64'(k));
      chk({nm, "_data"},  if0.out_data, e[k]);
      chk({nm, "_last"},  if0.out_last, (k == 3));
      @(posedge clk); #1;
    end
    if0.out_ready = 1'b0;
    fc0++;
    #1;
    chk({nm, "_end"}, if0.out_valid, 0);
    chk({nm, "_fc"},  if0.frame_count, 64'(fc0));
  endtask

  // ---- dut2: stand-in core plus high-level scoreboard ----
  logic [23:0]  sq[$];
  logic [191:0] fq2[$];
  logic [15:0]  eq2[$];     // {index, data, last}
  int acc2 = 0, bins2 = 0;

  always @(negedge clk) begin
    if (!rst && if2.in_valid && if2.in_ready) begin
      sq.push_back(if2.in_data);
      acc2++;
      if (sq.size() == 8) begin
        logic [191:0] fr;
        for (int i = 0; i < 8; i++) fr[i*24 +: 24] = sq[i];
        fq2.push_back(fr);
        // core behaviour: bin k = reversed sample, re/im swapped, +k on new imag
        for (int k = 0; k < 8; k++) begin
          int nre, nim;
          nre = int'(sq[7-k][11:0]);
          nim = (int'(sq[7-k][23:12]) + k) & 12'hFFF;
          eq2.push_back({3'(k), 6'(red(nre, 12, 6, 0)), 6'(red(nim, 12, 6, 0)), (k == 7)});
        end
        sq.delete();
      end
    end
    if (!rst && if2.out_valid && if2.out_ready) begin
      n_tests++;
      if (eq2.size() == 0) begin
        n_fail++;
        $display("FAIL t6_bin: unexpected bin idx %0d data %0h", if2.out_index, if2.out_data);
      end else begin
        logic [15:0] e;
        e = eq2.pop_front();
        if ({if2.out_index, if2.out_data, if2.out_last} !== e) begin
          n_fail++;
          $display("FAIL t6_bin: got %0h, expected %0h", {if2.out_index, if2.out_data, if2.out_last}, e);
        end
      end
      bins2++;
    end
  end

  initial begin
    logic [191:0] fr, res;
    logic [23:0]  s;
    if2.core_done   = 1'b0;
    if2.core_result = '0;
    forever begin
      @(posedge clk); #2;
      if (if2.core_start) begin
        fr = if2.core_samples;
        n_tests++;
        if (fq2.size() == 0) begin
          n_fail++;
          $display("FAIL t6_frame: core_start with no complete frame");
        end else if (fq2.pop_front() !== fr) begin
          n_fail++;
          $display("FAIL t6_frame: core_samples %0h differ from accepted samples", fr);
        end
        for (int k = 0; k < 8; k++) begin
          s = fr[(7-k)*24 +: 24];
          res[k*24 +: 24] = {s[11:0], 12'(s[23:12] + 12'(k))};
        end
        repeat (1 + $urandom_range(0, 3)) @(posedge clk);
        #2;
        if2.core_result = res;
        if2.core_done   = 1'b1;
        @(posedge clk); #2;
        if2.core_done   = 1'b0;
      end
    end
  end

  // ---- main sequence ----
  initial begin
    v1_t t1[4];
    v2_t t2[4];
    b4_t are, aim, ae, rre, rim, re_e, bre, bim, be, bre2, bim2, be2;
    t1[0] = '{8'd1, 8'd0, 8'd10,  8'h00, 8'h00};
    t1[1] = '{8'd2, 8'd0, 8'hFE,  8'h02, 8'hF0};
    t1[2] = '{8'd3, 8'd0, 8'hFE,  8'h00, 8'hF0};
    t1[3] = '{8'd4, 8'd0, 8'hFE,  8'hFE, 8'hFF};
    t2[0] = '{8'h5A, 4'h5, 4'h6};
    t2[1] = '{8'h7F, 4'h7, 4'h7};
    t2[2] = '{8'hFD, 4'hF, 4'h0};
    t2[3] = '{8'h80, 4'h8, 4'h8};

    rst = 1'b1;
    if0.ena = 1'b1; if0.abort = 1'b0; if0.in_valid = 1'b0; if0.in_data = '0;
    if0.core_done = 1'b0; if0.core_result = '0; if0.out_ready = 1'b0;
    if1.ena = 1'b1; if1.abort = 1'b0; if1.in_valid = 1'b0; if1.in_data = '0;
    if1.core_done = 1'b0; if1.core_result = '0; if1.out_ready = 1'b0;
    if2.ena = 1'b1; if2.abort = 1'b0; if2.in_valid = 1'b0; if2.in_data = '0;
    if2.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready",  if0.in_ready, 1);
    chk("rst_out_valid", if0.out_valid, 0);
    chk("rst_start",     if0.core_start, 0);
    chk("rst_status",    if0.status, 0);
    chk("rst_fc",        if0.frame_count, 0);
    chk("rst_out",       {if0.out_data, if0.out_index, if0.out_last}, 0);
    chk("rst_samples",   if0.core_samples, 0);

    // test 1: default frame, truncating reduction
    for (int i = 0; i < 4; i++) begin
      are[i] = t1[i].s_re; aim[i] = t1[i].s_im;
      rre[i] = t1[i].r_re; rim[i] = t1[i].r_im; re_e[i] = t1[i].exp;
    end
    for (int i = 0; i < 4; i++) begin
      if0.in_valid = 1'b1;
      if0.in_data  = {t1[i].s_re, t1[i].s_im};
      #1;
      chk("t1_ready", if0.in_ready, 1);
      chk("t1_nostart", if0.core_start, 0);
      @(posedge clk); #1;
    end
    if0.in_valid = 1'b0;
    #1;
    chk("t1_start",   if0.core_start, 1);
    chk("t1_samples", if0.core_samples, pack4(are, aim));
    chk("t1_full",    if0.in_ready, 0);
    @(posedge clk); #1;
    chk("t1_pulse",   if0.core_start, 0);
    chk("t1_comp",    if0.status, 2'b01);
    if0.core_result = pack4(rre, rim);
    if0.core_done   = 1'b1;
    #1;
    chk("t1_noval",   if0.out_valid, 0);
    @(posedge clk); #1;
    if0.core_done = 1'b0;
    #1;
    chk("t1_val",     if0.out_valid, 1);
    chk("t1_drain",   if0.status, 2'b10);
    chk("t1_reready", if0.in_ready, 1);
    drain0(re_e, "t1");

    // test 2: the same bins through truncating and rounding instances
    for (int i = 0; i < 4; i++) begin
      if0.in_valid = 1'b1; if1.in_valid = 1'b1;
      if0.in_data = 16'(i); if1.in_data = 16'(i);
      @(posedge clk); #1;
    end
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    #1;
    chk("t2_start0", if0.core_start, 1);
    chk("t2_start1", if1.core_start, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) rre[i] = t2[i].val;
    if0.core_result = pack4(rre, rre); if1.core_result = pack4(rre, rre);
    if0.core_done = 1'b1; if1.core_done = 1'b1;
    @(posedge clk); #1;
    if0.core_done = 1'b0; if1.core_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if0.out_ready = 1'b1; if1.out_ready = 1'b1;
      #1;
      chk("t2_trunc", if0.out_data, {t2[i].e0, t2[i].e0});
      chk("t2_round", if1.out_data, {t2[i].e1, t2[i].e1});
      @(posedge clk); #1;
    end
    if0.out_ready = 1'b0; if1.out_ready = 1'b0;
    fc0++;
    #1;
    chk("t2_fc", if0.frame_count, 64'(fc0));
    chk("t2_fc1", if1.frame_count, 1);

    // test 3: backpressure mid-drain while the next frame loads
    rnd_frame(are, aim, ae);
    rnd_frame(rre, rim, re_e);
    rnd_frame(bre, bim, be);
    rnd_frame(bre2, bim2, be2);
    loadn0(are, aim, 0, 3);
    #1;
    chk("t3_start", if0.core_start, 1);
    @(posedge clk); #1;
    done0(rre, rim);
    for (int k = 0; k < 2; k++) begin
      if0.out_ready = 1'b1;
      #1;
      chk("t3_idx", if0.out_index, 64'(k));
      chk("t3_data", if0.out_data, re_e[k]);
      @(posedge clk); #1;
    end
    if0.out_ready = 1'b0;
    for (int h = 0; h < 5; h++) begin
      if0.in_valid = (h < 4);
      if0.in_data  = {bre[h % 4], bim[h % 4]};
      #1;
      chk("t3_hold_idx",  if0.out_index, 2);
      chk("t3_hold_data", if0.out_data, re_e[2]);
      chk("t3_hold_val",  if0.out_valid, 1);
      if (h < 4) chk("t3_load_ready", if0.in_ready, 1);
      if (h == 4) begin
        chk("t3_status11", if0.status, 2'b11);
        chk("t3_wait",     if0.core_start, 0);
      end
      @(posedge clk); #1;
    end
    if0.in_valid = 1'b0;
    for (int k = 2; k < 4; k++) begin
      if0.out_ready = 1'b1;
      #1;
      chk("t3_idx", if0.out_index, 64'(k));
      chk("t3_data", if0.out_data, re_e[k]);
      chk("t3_last", if0.out_last, (k == 3));
      chk("t3_wait", if0.core_start, 0);
      @(posedge clk); #1;
    end
    if0.out_ready = 1'b0;
    fc0++;
    #1;
    chk("t3_end",    if0.out_valid, 0);
    chk("t3_launch", if0.core_start, 1);
    chk("t3_samples", if0.core_samples, pack4(bre, bim));
    chk("t3_fc",     if0.frame_count, 64'(fc0));
    @(posedge clk); #1;
    done0(bre2, bim2);
    drain0(be2, "t3b");

    // test 4: core_done while loading and in the core_start cycle
    rnd_frame(are, aim, ae);
    rnd_frame(rre, rim, re_e);
    loadn0(are, aim, 0, 1);
    if0.core_result = {64{1'b1}};
    if0.core_done   = 1'b1;
    @(posedge clk); #1;
    if0.core_done = 1'b0;
    #1;
    chk("t4_load_noval", if0.out_valid, 0);
    chk("t4_load_stat",  if0.status, 0);
    loadn0(are, aim, 2, 3);
    if0.core_done = 1'b1;
    #1;
    chk("t4_start", if0.core_start, 1);
    @(posedge clk); #1;
    if0.core_done = 1'b0;
    #1;
    chk("t4_early_noval", if0.out_valid, 0);
    chk("t4_early_stat",  if0.status, 2'b01);
    done0(rre, rim);
    drain0(re_e, "t4");

    // test 5: abort while computing, stray done, then ena stalls
    rnd_frame(are, aim, ae);
    rnd_frame(rre, rim, re_e);
    loadn0(are, aim, 0, 3);
    @(posedge clk); #1;
    chk("t5_comp", if0.status, 2'b01);
    if0.abort = 1'b1;
    @(posedge clk); #1;
    if0.abort = 1'b0;
    fc0 = 0;
    #1;
    chk("t5_ab_stat",  if0.status, 0);
    chk("t5_ab_ready", if0.in_ready, 1);
    chk("t5_ab_val",   if0.out_valid, 0);
    chk("t5_ab_start", if0.core_start, 0);
    chk("t5_ab_fc",    if0.frame_count, 0);
    if0.core_result = pack4(rre, rim);
    if0.core_done   = 1'b1;
    @(posedge clk); #1;
    if0.core_done = 1'b0;
    #1;
    chk("t5_stray_val", if0.out_valid, 0);
    chk("t5_stray_stat", if0.status, 0);
    loadn0(are, aim, 0, 3);
    if0.ena = 1'b0;
    #1;
    chk("t5_ena_nostart", if0.core_start, 0);
    @(posedge clk); #1;
    if0.ena = 1'b1;
    #1;
    chk("t5_ena_start", if0.core_start, 1);
    @(posedge clk); #1;
    chk("t5_ena_comp", if0.status, 2'b01);
    if0.ena = 1'b0;
    if0.core_result = pack4(rre, rim);
    if0.core_done   = 1'b1;
    @(posedge clk); #1;
    chk("t5_ena_nodone", if0.out_valid, 0);
    if0.ena = 1'b1;
    @(posedge clk); #1;
    if0.core_done = 1'b0;
    drain0(re_e, "t5");

    // test 6: N=8 back-to-back, 3 frames with valid/ready held high
    if2.out_ready = 1'b1;
    for (int c = 0; c < 600 && bins2 < 24; c++) begin
      if2.in_valid = (acc2 < 24);
      if2.in_data  = 24'($urandom);
      @(posedge clk); #1;
    end
    if2.in_valid = 1'b0;
    #1;
    chk("t6_bins",  64'(bins2), 24);
    chk("t6_fc",    if2.frame_count, 3);
    chk("t6_empty", 64'(eq2.size()), 0);

    // randomized valid/ready against the scoreboard
    for (int c = 0; c < 4000 && bins2 < 64; c++) begin
      if2.in_valid  = (acc2 < 64) && ($urandom_range(0, 9) < 7);
      if2.in_data   = 24'($urandom);
      if2.out_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk); #1;
    end
    if2.in_valid = 1'b0; if2.out_ready = 1'b0;
    #1;
    chk("rnd_bins",  64'(bins2), 64);
    chk("rnd_fc",    if2.frame_count, 8);
    chk("rnd_empty", 64'(eq2.size()), 0);
    chk("rnd_idle",  if2.status, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
